blram_gen: RTL and testbench
============================

BLRAM_GEN -- requirements
Module: blram_gen

Interface — parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_LEN, default 14, giving the address width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 16384, giving the number of words; it SHALL be ≤ 2^ADDR_LEN and need not be a power of two.
REQ-004 The block SHALL have parameter RD_LAT, default 1, giving the read latency in cycles; legal values are 1 and 2.
REQ-005 The block SHALL have parameter WR_MODE, default 0, selecting write-port read data: 0 = read-first (old data), 1 = write-first (merged new data).
REQ-006 The block SHALL have parameter CLR_ON_RST, default 1, where 1 = zero the whole array after reset.
REQ-007 The block SHALL have parameter INIT_FILE, default "", naming a hex file loaded at elaboration when non-empty.

Interface — ports
REQ-008 The block SHALL have port clk, input, width 1, as the single clock; all logic is on the rising edge.
REQ-009 The block SHALL have port rst, input, width 1, as a synchronous, active-high reset.
REQ-010 The block SHALL have port i_req, input, width 1, flagging that an access is presented this cycle.
REQ-011 The block SHALL have port i_we, input, width 1, where 1 = write and 0 = read; it is qualified by i_req.
REQ-012 The block SHALL have port i_be, input, width DATA_W/8, as byte enables for writes, with bit n covering byte n.
REQ-013 The block SHALL have port i_addr, input, width ADDR_LEN, as the word address.
REQ-014 The block SHALL have port i_ram_data_in, input, width DATA_W, as write data.
REQ-015 The block SHALL have port o_ram_data_out, output, width DATA_W, as read data.
REQ-016 The block SHALL have port o_rvalid, output, width 1, pulsing with o_ram_data_out for every accepted access.
REQ-017 The block SHALL have port o_ready, output, width 1, where 1 = accesses accepted and 0 = clearing or in reset.

Function
REQ-018 An access SHALL be accepted on a rising edge when i_req=1 and o_ready=1; i_req with o_ready=0 SHALL be dropped with no write and no o_rvalid.
REQ-019 A write SHALL update only the bytes whose i_be bit is 1; i_be=0 SHALL perform a no-op write that still returns data.
REQ-020 Every accepted access SHALL produce exactly one o_rvalid pulse exactly RD_LAT cycles after acceptance, and accesses SHALL be fully pipelined at one per cycle.
REQ-021 o_ram_data_out for a read SHALL be the word contents at the acceptance edge.
REQ-022 o_ram_data_out for a write SHALL be the pre-write word when WR_MODE=0 and the post-merge word when WR_MODE=1.
REQ-023 For back-to-back accesses to the same address, a read SHALL observe all writes accepted in earlier cycles.
REQ-024 An access with i_addr ≥ MEM_DEPTH SHALL NOT write memory and SHALL return all-zero data with o_rvalid still asserted.
REQ-025 o_ram_data_out SHALL hold its last value while o_rvalid=0.
REQ-026 When RD_LAT=2, the second stage SHALL be a register with no added logic.
REQ-027 The block SHALL implement a control FSM with states RESET, CLEAR and READY.
REQ-028 The FSM SHALL be in RESET while rst=1; on the first edge with rst=0 it SHALL move to CLEAR if CLR_ON_RST=1, else to READY.
REQ-029 In CLEAR, an address counter starting at 0 SHALL write all-zero to one word per cycle, with edge k after deassertion writing address k-1.
REQ-030 After writing address MEM_DEPTH-1 the FSM SHALL enter READY, and o_ready SHALL rise on that same edge, so clear takes MEM_DEPTH cycles.
REQ-031 o_ready SHALL be a registered output and SHALL be 1 only in READY.
REQ-032 Array contents SHALL come from INIT_FILE at time 0 when it is non-empty, else they are undefined; CLR_ON_RST=1 overrides the file after every reset.

Reset
REQ-033 While rst=1, o_rvalid, all pipeline valids, o_ram_data_out and o_ready SHALL be 0 from the first edge with rst=1.
REQ-034 While rst=1, no memory write SHALL occur and the clear counter SHALL be 0.
REQ-035 Reset asserted mid-clear SHALL abort the clear, and the clear SHALL restart from address 0 after deassertion.
REQ-036 Reset asserted mid-pipeline SHALL discard in-flight reads with no o_rvalid; a write already accepted stays committed.
REQ-037 With CLR_ON_RST=0, reset SHALL NOT alter array contents.

Verification (DATA_W=32, ADDR_LEN=4, MEM_DEPTH=12 unless stated)
REQ-038 Clear scenario: rst high for 2 cycles then low, CLR_ON_RST=1 -> o_ready=0 for exactly 12 edges then 1; reads of addresses 0..11 return 0x00000000.
REQ-039 Byte-enable scenario: write 0xAABBCCDD to address 3 with be=1111, then 0x11223344 with be=0101, then read address 3 -> 0xAA22CC44 with o_rvalid exactly RD_LAT cycles after the read request (run with RD_LAT=1 and 2).
REQ-040 Write-mode scenario: address 5 holds 0x00000007; write 0x00000009 -> o_ram_data_out=0x00000007 when WR_MODE=0 and 0x00000009 when WR_MODE=1; a following read returns 0x00000009.
REQ-041 Back-to-back scenario: write address 2 = 0x5, then read address 2 in the next cycle, then write address 2 = 0x6 and read again in consecutive cycles -> reads return 0x5 then 0x6, with one o_rvalid per access.
REQ-042 Range scenario: write address 13 with 0xFFFFFFFF -> o_rvalid with data 0 and addresses 0..11 unchanged; i_req during CLEAR -> no o_rvalid.
REQ-043 Reset-abort scenario: rst at clear address 6 for 1 cycle -> clear restarts at address 0 and o_ready rises 12 edges after deassertion; a read in flight when rst rises produces no o_rvalid.

Source files
------------

// File: rtl/blram_gen.sv
// blram_gen: single-port block RAM with byte enables, a 1- or 2-cycle read
// pipeline and an optional zero-fill of the whole array after reset.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   i_req           access presented this cycle
//   i_we            1 = write, 0 = read (qualified by i_req)
//   i_be            per-byte write enables (bit n -> byte n)
//   i_addr          word address; addresses >= MEM_DEPTH are ignored, read as 0
//   i_ram_data_in   write data
//   o_ram_data_out  response data, held between o_rvalid pulses
//   o_rvalid        one pulse per accepted access, RD_LAT cycles later
//   o_ready         1 when accesses are accepted (low in reset and clear)
module blram_gen #(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_LEN   = 14,
  parameter int    MEM_DEPTH  = 16384,
  parameter int    RD_LAT     = 1,
  parameter int    WR_MODE    = 0,
  parameter int    CLR_ON_RST = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [DATA_W-1:0]   i_ram_data_in,
  output logic [DATA_W-1:0]   o_ram_data_out,
  output logic                o_rvalid,
  output logic                o_ready
);

  localparam int NB = DATA_W / 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state, state_nx;
  logic [AW-1:0]     clr_cnt;
  logic              clr_we;
  logic              acc, in_rng;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_old, merged, rsp;
  logic              vld_s1;
  logic [DATA_W-1:0] dat_s1;

  // ---------------- control FSM ----------------
  // The first edge after reset release already clears word 0, so the
  // clear spans exactly MEM_DEPTH edges and o_ready rises on the last one.
  always_comb begin
    state_nx = state;
    clr_we   = 1'b0;
    case (state)
      RESET: begin
        if (CLR_ON_RST != 0) begin
          clr_we   = 1'b1;
          state_nx = (MEM_DEPTH == 1) ? READY : CLEAR;
        end else begin
          state_nx = READY;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == AW'(MEM_DEPTH - 1)) state_nx = READY;
      end
      default: state_nx = state;
    endcase
    if (rst) begin
      state_nx = RESET;
      clr_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state   <= state_nx;
    o_ready <= (state_nx == READY);
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---------------- access path ----------------
  // Wide compare so MEM_DEPTH == 2**ADDR_LEN does not truncate to 0.
  assign in_rng = {1'b0, i_addr} < (ADDR_LEN + 1)'(MEM_DEPTH);
  assign idx    = i_addr[AW-1:0];
  assign acc    = i_req && o_ready && !rst;
  assign rd_old = in_rng ? mem[idx] : '0;

  always_comb begin
    merged = rd_old;
    for (int b = 0; b < NB; b++)
      if (i_be[b]) merged[b*8 +: 8] = i_ram_data_in[b*8 +: 8];
  end

  // Out-of-range accesses answer zero regardless of write mode.
  assign rsp = !in_rng ? '0 :
               ((WR_MODE != 0) && i_we) ? merged : rd_old;

  // Clear and accesses are exclusive: o_ready is low while clearing.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_cnt] <= '0;
    else if (acc && i_we && in_rng)
      mem[idx] <= merged;
  end

  // Stage-1 data only moves on an accepted access, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_s1 <= 1'b0;
      dat_s1 <= '0;
    end else begin
      vld_s1 <= acc;
      if (acc) dat_s1 <= rsp;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              vld_s2;
    logic [DATA_W-1:0] dat_s2;
    // Plain retiming register; it only changes the cycle after stage 1
    // changed, which is exactly when vld_s2 pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_s2 <= 1'b0;
        dat_s2 <= '0;
      end else begin
        vld_s2 <= vld_s1;
        dat_s2 <= dat_s1;
      end
    end
    assign o_rvalid       = vld_s2;
    assign o_ram_data_out = dat_s2;
  end else begin : g_lat1
    assign o_rvalid       = vld_s1;
    assign o_ram_data_out = dat_s1;
  end

endmodule

// File: tb/tb_blram_gen.sv
// tb_blram_gen: drives two blram_gen instances (RD_LAT=1/read-first and
// RD_LAT=2/write-first) with identical stimulus and compares both against
// a word-array reference model with per-instance expected-response queues.
module tb_blram_gen;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [3:0]  be, addr;
  logic [31:0] din;
  logic [31:0] d1, d2;
  logic        v1, v2, r1, r2;

  always #5 clk = ~clk;

  blram_gen #(.DATA_W(32), .ADDR_LEN(4), .MEM_DEPTH(12), .RD_LAT(1),
              .WR_MODE(0), .CLR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_be(be), .i_addr(addr),
    .i_ram_data_in(din), .o_ram_data_out(d1), .o_rvalid(v1), .o_ready(r1));

  blram_gen #(.DATA_W(32), .ADDR_LEN(4), .MEM_DEPTH(12), .RD_LAT(2),
              .WR_MODE(1), .CLR_ON_RST(1)) dut2 (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_be(be), .i_addr(addr),
    .i_ram_data_in(din), .o_ram_data_out(d2), .o_rvalid(v2), .o_ready(r2));

  typedef struct { int due; logic [31:0] d; } exp_t;

  int          total = 0, bad = 0, cyc = 0;
  logic [31:0] mdl [16];
  int          clr_left = 12;
  bit          rdy = 1'b0;
  exp_t        q1[$], q2[$];
  logic [31:0] last1 = '0, last2 = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  // One clock: apply inputs, predict, clock, then check both instances.
  task automatic step(input logic r, input logic q, input logic w,
                      input logic [3:0] b, input logic [3:0] a,
                      input logic [31:0] d);
    logic        acc, inr, ev;
    logic [31:0] old, mg;
    rst = r; req = q; we = w; be = b; addr = a; din = d;
    acc = q && rdy && !r;
    inr = (a < 12);
    if (acc) begin
      old = inr ? mdl[a] : 32'h0;
      mg  = old;
      for (int i = 0; i < 4; i++) if (b[i]) mg[i*8 +: 8] = d[i*8 +: 8];
      if (w && inr) mdl[a] = mg;
      q1.push_back('{cyc + 1, old});
      q2.push_back('{cyc + 2, (w && inr) ? mg : old});
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      rdy = 1'b0;
      clr_left = 12;
      while (q1.size() > 0 && q1[$].due >= cyc) void'(q1.pop_back());
      while (q2.size() > 0 && q2[$].due >= cyc) void'(q2.pop_back());
      last1 = '0;
      last2 = '0;
    end else if (clr_left > 0) begin
      mdl[12 - clr_left] = '0;
      clr_left--;
      rdy = (clr_left == 0);
    end
    #1;
    chk("ready1", {31'b0, r1}, {31'b0, rdy});
    chk("ready2", {31'b0, r2}, {31'b0, rdy});
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    chk("rvalid1", {31'b0, v1}, {31'b0, ev});
    if (ev) begin last1 = q1[0].d; void'(q1.pop_front()); end
    chk("data1", d1, last1);
    ev = (q2.size() > 0) && (q2[0].due == cyc);
    chk("rvalid2", {31'b0, v2}, {31'b0, ev});
    if (ev) begin last2 = q2[0].d; void'(q2.pop_front()); end
    chk("data2", d2, last2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, b, a, d);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 'x;

    // Reset 2 cycles, then clear with a request offered mid-clear.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b1, 4'hF, 4'h1, 32'hDEADBEEF);
    idle(6);
    for (int i = 0; i < 12; i++) rd(4'(i));
    idle(2);

    // Byte enables.
    wr(4'h3, 4'hF, 32'hAABBCCDD);
    wr(4'h3, 4'h5, 32'h11223344);
    rd(4'h3);
    chk("be_lat1", d1, 32'hAA22CC44);
    idle(1);
    chk("be_lat2", d2, 32'hAA22CC44);
    idle(1);

    // Write mode: read-first vs write-first response.
    wr(4'h5, 4'hF, 32'h7);
    wr(4'h5, 4'hF, 32'h9);
    chk("wm_rdfirst", d1, 32'h7);
    rd(4'h5);
    chk("wm_rd", d1, 32'h9);
    chk("wm_wrfirst", d2, 32'h9);
    idle(2);

    // Back-to-back same address.
    wr(4'h2, 4'hF, 32'h5);
    rd(4'h2);
    wr(4'h2, 4'hF, 32'h6);
    rd(4'h2);
    idle(2);

    // Out of range write, then sweep to confirm nothing changed.
    wr(4'hD, 4'hF, 32'hFFFFFFFF);
    wr(4'hC, 4'h0, 32'h12345678);
    for (int i = 0; i < 12; i++) rd(4'(i));
    idle(2);

    // Fill memory, then reset with a read in flight, abort clear at addr 6.
    for (int i = 0; i < 12; i++) wr(4'(i), 4'hF, $urandom | 32'h1);
    rd(4'h4);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(12);
    for (int i = 0; i < 12; i++) rd(4'(i));
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++)
      step(1'b0, ($urandom_range(0, 9) < 8), 1'($urandom), 4'($urandom),
           4'($urandom_range(0, 15)), $urandom);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
